// File: rtl/proc_pkg.sv
// Shared types and sizes for the pixel processing pipeline.
package proc_pkg;

  localparam int unsigned COLOR_SIZE = 8;
  localparam int unsigned PIXEL_SIZE = 24;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_THRESH = 2'd1,
    MODE_BRIGHT = 2'd2,
    MODE_DARK   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/proc_lane.sv
// One colour-byte lane: pass, threshold, saturating brighten or saturating darken.
module proc_lane
  import proc_pkg::*;
(
  input  logic [1:0] mode,
  input  logic [7:0] proc_val,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  logic [8:0] sum;

  always_comb begin
    sum      = {1'b0, data_in} + {1'b0, proc_val};
    data_out = data_in;
    case (mode_e'(mode))
      MODE_PASS:   data_out = data_in;
      MODE_THRESH: data_out = (data_in >= proc_val) ? 8'hFF : 8'h00;
      MODE_BRIGHT: data_out = sum[8] ? 8'hFF : sum[7:0];
      MODE_DARK:   data_out = (data_in > proc_val) ? (data_in - proc_val) : 8'h00;
      default:     data_out = data_in;
    endcase
  end

endmodule

// File: rtl/pixel_proc_pipe.sv
// Two-stage pixel processing pipeline with valid/ready handshake, per-frame
// latching of mode/proc_val and a saturating frame beat counter.
module pixel_proc_pipe
  import proc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic                  in_last,
  input  logic [1:0]            mode,
  input  logic [7:0]            proc_val,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic                  out_last,
  output logic [CNT_WIDTH-1:0]  beat_cnt,
  output logic                  done
);

  localparam int unsigned LANES = DATA_WIDTH / COLOR_SIZE;

  state_e                state;
  logic [1:0]            mode_q;
  logic [7:0]            val_q;
  logic                  s1_vld;
  logic                  s1_last;
  logic [DATA_WIDTH-1:0] s1_data;
  logic [DATA_WIDTH-1:0] result;
  logic                  en;
  logic                  in_xfer;
  logic                  out_xfer;

  // Whole pipeline advances together; in_rdy never looks at in_vld.
  assign en       = !out_vld || out_rdy;
  assign in_rdy   = en && (state != FLUSH);
  assign in_xfer  = in_vld && in_rdy;
  assign out_xfer = out_vld && out_rdy;
  assign done     = (state == FLUSH) && out_xfer && out_last;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    proc_lane u_lane (
      .mode     (mode_q),
      .proc_val (val_q),
      .data_in  (s1_data[l*COLOR_SIZE +: COLOR_SIZE]),
      .data_out (result[l*COLOR_SIZE +: COLOR_SIZE])
    );
  end

  // S1 captures raw beat, S2 holds the processed beat presented downstream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld   <= 1'b0;
      s1_last  <= 1'b0;
      s1_data  <= '0;
      out_vld  <= 1'b0;
      out_last <= 1'b0;
      data_out <= '0;
    end else if (en) begin
      s1_vld  <= in_xfer;
      out_vld <= s1_vld;
      if (in_xfer) begin
        s1_data <= data_in;
        s1_last <= in_last;
      end
      if (s1_vld) begin
        data_out <= result;
        out_last <= s1_last;
      end
    end
  end

  // Frame FSM: latches operation on the first beat, counts beats, waits for the last beat to drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      mode_q   <= 2'd0;
      val_q    <= 8'd0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_xfer) begin
            mode_q   <= mode;
            val_q    <= proc_val;
            beat_cnt <= CNT_WIDTH'(1);
            state    <= in_last ? FLUSH : RUN;
          end
        end
        RUN: begin
          if (in_xfer) begin
            if (beat_cnt != {CNT_WIDTH{1'b1}}) beat_cnt <= beat_cnt + CNT_WIDTH'(1);
            if (in_last) state <= FLUSH;
          end
        end
        FLUSH: begin
          if (done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_proc_pipe.sv
// Scoreboard bench for pixel_proc_pipe: 32-bit instance for directed/random frames,
// 64-bit instance for a long frame that saturates the beat counter.
module tb_pixel_proc_pipe;

  localparam int unsigned DW        = 32;
  localparam int unsigned SDW       = 64;
  localparam int unsigned CW        = 16;
  localparam int          SAT_BEATS = 70000;

  typedef struct packed {
    logic [63:0] d;
    logic        l;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, in_vld, in_rdy, in_last, out_vld, out_rdy, out_last, done;
  logic [1:0]    mode;
  logic [7:0]    proc_val;
  logic [DW-1:0] data_in, data_out;
  logic [CW-1:0] beat_cnt;

  logic           s_rst_n, s_in_vld, s_in_rdy, s_in_last, s_out_vld, s_out_rdy, s_out_last, s_done;
  logic [1:0]     s_mode;
  logic [7:0]     s_val;
  logic [SDW-1:0] s_data_in, s_data_out;
  logic [CW-1:0]  s_beat_cnt;

  pixel_proc_pipe #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy), .in_last(in_last),
    .mode(mode), .proc_val(proc_val), .data_in(data_in), .data_out(data_out),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_last(out_last), .beat_cnt(beat_cnt), .done(done)
  );

  pixel_proc_pipe #(.DATA_WIDTH(SDW), .CNT_WIDTH(CW)) u_sat (
    .clk(clk), .rst_n(s_rst_n), .in_vld(s_in_vld), .in_rdy(s_in_rdy), .in_last(s_in_last),
    .mode(s_mode), .proc_val(s_val), .data_in(s_data_in), .data_out(s_data_out),
    .out_vld(s_out_vld), .out_rdy(s_out_rdy), .out_last(s_out_last), .beat_cnt(s_beat_cnt), .done(s_done)
  );

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];
  exp_t sq[$];
  int   lat_m, lat_v, done_cnt, s_done_cnt, s_outs;
  bit   in_frame, rdy_rand, sat_fin;
  logic [31:0] bp [4] = '{32'h0102_0304, 32'h1112_1314, 32'h2122_2324, 32'h3132_3334};

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each byte treated as an integer 0..255 and processed by the operation's rule.
  function automatic logic [63:0] ref_word(int m, int v, logic [63:0] d, int lanes);
    logic [63:0] r;
    r = '0;
    for (int b = 0; b < lanes; b++) begin
      int x;
      int y;
      x = int'(d[8*b +: 8]);
      case (m)
        0:       y = x;
        1:       y = (x >= v) ? 255 : 0;
        2:       y = (x + v > 255) ? 255 : x + v;
        default: y = (x > v) ? x - v : 0;
      endcase
      r[8*b +: 8] = 8'(y);
    end
    return r;
  endfunction

  task automatic model_accept(logic [31:0] d, bit last, logic [1:0] m, logic [7:0] v);
    exp_t e;
    if (!in_frame) begin
      lat_m    = int'(m);
      lat_v    = int'(v);
      in_frame = 1'b1;
    end
    e.d = ref_word(lat_m, lat_v, {32'd0, d}, 4);
    e.l = last;
    q.push_back(e);
    if (last) in_frame = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send(logic [31:0] d, bit last, logic [1:0] m, logic [7:0] v);
    bit acc;
    int n;
    n = 0;
    in_vld = 1'b1; data_in = d; in_last = last; mode = m; proc_val = v;
    do begin
      @(negedge clk) acc = in_rdy;
      @(posedge clk);
      n++;
      #1;
    end while (!acc && n < 2000);
    if (!acc) begin
      total++; bad++;
      $display("FAIL send_timeout actual=no_accept required=accept");
    end else model_accept(d, last, m, v);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_vld) && n < 500) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 500) begin
      total++; bad++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", q.size());
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rdy_rand) out_rdy = ($urandom_range(0, 3) != 0);
  end

  // Main monitor: pops on every output transfer, checks hold during stalls and done.
  bit          stall;
  logic [31:0] hd;
  logic        hl;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) stall = 1'b0;
    else begin
      if (stall) begin
        check("hold_vld", out_vld, 1);
        check("hold_data", data_out, hd);
        check("hold_last", out_last, hl);
      end
      if (out_vld && out_rdy) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_out actual=%h required=none", data_out);
        end else begin
          e = q.pop_front();
          check("data", data_out, e.d[31:0]);
          check("last", out_last, e.l);
          check("done", done, e.l);
        end
      end else check("done_idle", done, 0);
      if (done) done_cnt++;
      stall = out_vld && !out_rdy;
      hd = data_out;
      hl = out_last;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (s_rst_n && s_out_vld && s_out_rdy) begin
      s_outs++;
      if (sq.size() == 0) begin
        total++; bad++;
        $display("FAIL sat_unexpected_out actual=%h required=none", s_data_out);
      end else begin
        e = sq.pop_front();
        check("sat_data", s_data_out, e.d);
        check("sat_done", s_done, e.l);
      end
    end
    if (s_done) s_done_cnt++;
  end

  // Long 64-bit frame: counter must saturate, exactly one done.
  initial begin
    exp_t e;
    bit   acc;
    int   n;
    logic [63:0] d;
    s_rst_n = 1'b0; s_in_vld = 1'b0; s_in_last = 1'b0; s_mode = 2'd0; s_val = 8'd0;
    s_data_in = '0; s_out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1 s_rst_n = 1'b1;
    for (int i = 0; i < SAT_BEATS; i++) begin
      d = {$urandom, $urandom};
      s_data_in = d; s_in_last = (i == SAT_BEATS - 1); s_in_vld = 1'b1;
      s_mode = (i == 0) ? 2'd2 : 2'($urandom);
      s_val  = (i == 0) ? 8'h10 : 8'($urandom);
      n = 0;
      do begin
        @(negedge clk) acc = s_in_rdy;
        @(posedge clk);
        n++;
        #1;
      end while (!acc && n < 100);
      if (!acc) begin
        total++; bad++;
        $display("FAIL sat_send_timeout actual=no_accept required=accept");
        break;
      end
      e.d = ref_word(2, 16, d, 8);
      e.l = (i == SAT_BEATS - 1);
      sq.push_back(e);
    end
    s_in_vld = 1'b0;
    n = 0;
    while ((sq.size() != 0 || s_out_vld) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("sat_cnt", s_beat_cnt, 16'hFFFF);
    check("sat_done_cnt", s_done_cnt, 1);
    check("sat_outs", s_outs, SAT_BEATS);
    sat_fin = 1'b1;
  end

  initial begin
    int d0, len, n;
    logic [31:0] r;
    rst_n = 1'b0; in_vld = 1'b0; in_last = 1'b0; mode = 2'd0; proc_val = 8'd0;
    data_in = '0; out_rdy = 1'b1; rdy_rand = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_vld", out_vld, 0);
    check("rst_data_out", data_out, 0);
    check("rst_out_last", out_last, 0);
    check("rst_beat_cnt", beat_cnt, 0);
    check("rst_done", done, 0);
    check("rst_in_rdy", in_rdy, 1);
    @(posedge clk); #1;

    // Single-beat threshold frame, exact latency.
    send(32'h7F80_FF00, 1'b1, 2'd1, 8'h80);
    in_vld = 1'b0; in_last = 1'b0;
    @(negedge clk) check("thr_lat_early", out_vld, 0);
    @(negedge clk);
    check("thr_lat_vld", out_vld, 1);
    check("thr_data", data_out, 32'h00FF_FF00);
    check("thr_last", out_last, 1);
    check("thr_done", done, 1);
    check("thr_cnt", beat_cnt, 1);
    @(negedge clk);
    check("thr_cnt_hold", beat_cnt, 1);
    check("thr_idle_rdy", in_rdy, 1);
    @(posedge clk); #1;

    send(32'hF0E0_1000, 1'b1, 2'd2, 8'h20);
    in_vld = 1'b0;
    repeat (2) @(negedge clk);
    check("bright_data", data_out, 32'hFFFF_3020);
    @(posedge clk); #1;
    send(32'hF0E0_1000, 1'b1, 2'd3, 8'h20);
    in_vld = 1'b0;
    repeat (2) @(negedge clk);
    check("dark_data", data_out, 32'hD0C0_0000);
    @(posedge clk); #1;

    // Backpressure: out_rdy low for cycles 2-6 of a 4-beat pass frame.
    d0 = done_cnt;
    fork
      begin
        for (int i = 0; i < 4; i++) send(bp[i], i == 3, 2'd0, 8'd0);
        in_vld = 1'b0; in_last = 1'b0;
      end
      begin
        out_rdy = 1'b1;
        @(posedge clk) #1 out_rdy = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("bp_in_rdy", in_rdy, 0);
        check("bp_out_vld", out_vld, 1);
        check("bp_head", data_out, bp[0]);
        @(posedge clk) #1 out_rdy = 1'b1;
      end
    join
    wait_drain();
    check("bp_done_cnt", done_cnt - d0, 1);
    check("bp_cnt", beat_cnt, 4);

    // Mid-frame mode change is ignored.
    send($urandom, 1'b0, 2'd1, 8'h80);
    send($urandom, 1'b0, 2'd2, 8'h40);
    send($urandom, 1'b1, 2'd2, 8'h40);
    in_vld = 1'b0; in_last = 1'b0;
    wait_drain();
    check("mc_cnt", beat_cnt, 3);

    // Reset with two beats in flight.
    out_rdy = 1'b0;
    send($urandom, 1'b0, 2'd2, 8'h11);
    send($urandom, 1'b0, 2'd2, 8'h11);
    in_vld = 1'b0;
    @(negedge clk) check("rst_mid_inflight", out_vld, 1);
    @(posedge clk); #1 rst_n = 1'b0;
    d0 = done_cnt;
    @(posedge clk); #1 rst_n = 1'b1;
    q.delete();
    in_frame = 1'b0;
    @(negedge clk);
    check("rstm_out_vld", out_vld, 0);
    check("rstm_in_rdy", in_rdy, 1);
    check("rstm_cnt", beat_cnt, 0);
    @(posedge clk); #1 out_rdy = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rstm_no_done", done_cnt - d0, 0);
    send(32'h1020_3040, 1'b0, 2'd3, 8'h18);
    send(32'hFF00_8018, 1'b1, 2'd0, 8'h00);
    in_vld = 1'b0; in_last = 1'b0;
    wait_drain();
    check("rstm_next_cnt", beat_cnt, 2);

    // Random frames with bubbles, random backpressure and changing inputs mid-frame.
    rdy_rand = 1'b1;
    for (int f = 0; f < 25; f++) begin
      len = $urandom_range(1, 8);
      d0  = done_cnt;
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 2) == 0) begin
          in_vld = 1'b0; data_in = $urandom;
          repeat ($urandom_range(1, 2)) @(posedge clk);
          #1;
        end
        r = $urandom;
        send(r, b == len - 1, 2'($urandom), 8'($urandom));
      end
      in_vld = 1'b0; in_last = 1'b0;
      wait_drain();
      check("rnd_cnt", beat_cnt, len);
      check("rnd_done_cnt", done_cnt - d0, 1);
    end
    rdy_rand = 1'b0;
    out_rdy = 1'b1;

    n = 0;
    while (!sat_fin && n < 90000) begin
      @(posedge clk); n++;
    end
    if (!sat_fin) begin
      total++; bad++;
      $display("FAIL sat_timeout actual=unfinished required=finished");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
